// File: rtl/adc_pkg.sv
// Shared FSM state type and width helper for the multi-channel ADC scaler.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        HOLD
    } adc_state_e;

    // Largest value that fits in 'width' bits, i.e. full scale for that width.
    function automatic int unsigned all_ones(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/adc_seq_divider.sv
// Restoring divider: o_quot = floor(i_avg * (2^OUT_W-1) / (2^IN_W-1)), one quotient
// bit per cycle over OUT_W cycles; o_done pulses when the quotient is ready.
module adc_seq_divider
    import adc_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [IN_W-1:0]  i_avg,
    output logic             o_done,
    output logic [OUT_W-1:0] o_quot
);

    localparam int NUM_W = IN_W + OUT_W;
    localparam int CNT_W = $clog2(OUT_W + 1);
    localparam logic [IN_W-1:0] DIVISOR = IN_W'(all_ones(IN_W));

    logic [NUM_W-1:0] w_num;
    logic [IN_W:0]    w_trial;
    logic [IN_W:0]    w_diff;
    logic             w_fits;

    logic [IN_W-1:0]  r_rem;
    logic [OUT_W-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    // avg * (2^OUT_W - 1) without a multiplier.
    assign w_num   = {i_avg, {OUT_W{1'b0}}} - NUM_W'(i_avg);
    assign w_trial = {r_rem, r_shift[OUT_W-1]};
    assign w_fits  = w_trial >= {1'b0, DIVISOR};
    assign w_diff  = w_trial - {1'b0, DIVISOR};

    // The low numerator bits shift out as quotient bits shift in, so r_shift
    // ends up holding the quotient; the upper half always starts below DIVISOR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem   <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem   <= w_num[NUM_W-1:OUT_W];
                r_shift <= w_num[OUT_W-1:0];
                r_cnt   <= CNT_W'(OUT_W);
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_rem   <= w_fits ? w_diff[IN_W-1:0] : w_trial[IN_W-1:0];
                r_shift <= {r_shift[OUT_W-2:0], w_fits};
                r_cnt   <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_quot = r_shift;

endmodule

// File: rtl/multi_ch_adc_scaler.sv
// Per-channel averaging ADC front end with sequential rescaling to OUT_W bits.
// Define ADC_ALARM_EN to build the per-channel over-threshold alarm flags.
module multi_ch_adc_scaler
    import adc_pkg::*;
#(
    parameter int IN_W        = 12,
    parameter int OUT_W       = 8,
    parameter int NUM_CH      = 4,
    parameter int AVG_LOG2    = 2,
    parameter int ALARM_LEVEL = 200,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_data,
    output logic              err_ch,
    output logic              busy,
    output logic [NUM_CH-1:0] alarm
);

    localparam int ACC_W = IN_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    adc_state_e       r_state;
    logic [ACC_W-1:0] r_acc [NUM_CH];
    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [CH_W-1:0]  r_pend_ch;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic [CH_W-1:0]  r_out_ch;
    logic             r_err_ch;

    logic             w_accept;
    logic             w_ch_ok;
    logic             w_last;
    logic             w_start;
    logic [ACC_W-1:0] w_sum;
    logic [IN_W-1:0]  w_avg;
    logic             w_div_done;
    logic [OUT_W-1:0] w_quot;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_ch_ok  = 32'(in_ch) < NUM_CH;
    assign w_sum    = r_acc[in_ch] + ACC_W'(in_data);
    assign w_avg    = w_sum[ACC_W-1:AVG_LOG2];
    assign w_last   = (AVG_LOG2 == 0) || (r_cnt[in_ch] == {CNT_W{1'b1}});
    assign w_start  = w_accept && w_ch_ok && w_last;

    // NOTE: the accumulators are a handful of flops rather than a RAM, so they
    // take the synchronous reset like every other register here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
                r_cnt[c] <= '0;
            end
        end else if (w_accept && w_ch_ok) begin
            if (w_last) begin
                r_acc[in_ch] <= '0;
                r_cnt[in_ch] <= '0;
            end else begin
                r_acc[in_ch] <= w_sum;
                r_cnt[in_ch] <= r_cnt[in_ch] + CNT_W'(1);
            end
        end
    end

    adc_seq_divider #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_avg   (w_avg),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pend_ch   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_err_ch    <= 1'b0;
        end else begin
            r_err_ch <= w_accept && !w_ch_ok;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= DIV;
                        r_pend_ch <= in_ch;
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_quot;
                        r_out_ch    <= r_pend_ch;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign err_ch    = r_err_ch;

`ifdef ADC_ALARM_EN
    logic [NUM_CH-1:0] r_alarm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm <= '0;
        end else if (r_out_valid && out_ready) begin
            r_alarm[r_out_ch] <= (r_out_data >= OUT_W'(ALARM_LEVEL));
        end
    end

    assign alarm = r_alarm;
`else
    assign alarm = '0;
`endif

endmodule

// File: tb/tb_multi_ch_adc_scaler.sv
// Directed bench for multi_ch_adc_scaler: default instance plus a 5-channel,
// single-sample instance for the out-of-range channel and no-averaging cases.
module tb_multi_ch_adc_scaler;

    localparam int LAT = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready;
    logic [1:0]  in_ch;
    logic [11:0] in_data;
    logic        in_ready, out_valid, err_ch, busy;
    logic [1:0]  out_ch;
    logic [7:0]  out_data;
    logic [3:0]  alarm;

    logic        e_in_valid, e_out_ready;
    logic [2:0]  e_in_ch;
    logic [11:0] e_in_data;
    logic        e_in_ready, e_out_valid, e_err_ch, e_busy;
    logic [2:0]  e_out_ch;
    logic [7:0]  e_out_data;
    logic [4:0]  e_alarm;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_alarm = '0;

    always #5 clk = ~clk;

    multi_ch_adc_scaler u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .err_ch    (err_ch),
        .busy      (busy),
        .alarm     (alarm)
    );

    multi_ch_adc_scaler #(
        .NUM_CH   (5),
        .AVG_LOG2 (0)
    ) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (e_in_valid),
        .in_ready  (e_in_ready),
        .in_ch     (e_in_ch),
        .in_data   (e_in_data),
        .out_valid (e_out_valid),
        .out_ready (e_out_ready),
        .out_ch    (e_out_ch),
        .out_data  (e_out_data),
        .err_ch    (e_err_ch),
        .busy      (e_busy),
        .alarm     (e_alarm)
    );

    task automatic send(input logic [1:0] ch, input logic [11:0] d);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%b expected 1", in_ready);
        end
        in_valid = 1'b1; in_ch = ch; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send5(input logic [2:0] ch, input logic [11:0] d);
        int guard = 0;
        while (e_in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (e_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send5_ready: in_ready=%b expected 1", e_in_ready);
        end
        e_in_valid = 1'b1; e_in_ch = ch; e_in_data = d;
        @(posedge clk); #1;
        e_in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_result5(output int lat);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (e_out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Checks one finished conversion on the default instance, then consumes it.
    task automatic expect_result(input string name, input int ch, input int data);
        int lat;
        wait_result(lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, LAT);
        end
        n_checks++;
        if (out_ch !== 2'(ch) || out_data !== 8'(data)) begin
            n_fail++;
            $display("FAIL %s_value: got ch=%0d data=%0d expected ch=%0d data=%0d",
                     name, out_ch, out_data, ch, data);
        end
`ifdef ADC_ALARM_EN
        exp_alarm[ch] = (data >= 200);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alarm !== exp_alarm) begin
            n_fail++;
            $display("FAIL %s_consume: got valid=%b ready=%b alarm=%b expected 0 1 %b",
                     name, out_valid, in_ready, alarm, exp_alarm);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({out_valid, err_ch, busy} !== 3'b000 || out_data !== 8'd0 || out_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b e=%b b=%b d=%0d c=%0d expected all 0",
                     out_valid, err_ch, busy, out_data, out_ch);
        end
        n_checks++;
        if (in_ready !== 1'b1 || alarm !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready_alarm: got ready=%b alarm=%b expected 1 0000", in_ready, alarm);
        end
        n_checks++;
        if (e_in_ready !== 1'b1 || e_out_valid !== 1'b0 || e_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut5: got ready=%b valid=%b busy=%b expected 1 0 0",
                     e_in_ready, e_out_valid, e_busy);
        end
    endtask

    task automatic test_full_scale;
        for (int i = 0; i < 4; i++) send(2'd1, 12'd4095);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_div_state: got busy=%b ready=%b expected 1 0", busy, in_ready);
        end
        expect_result("full_scale", 1, 255);
    endtask

    task automatic test_mid_scale;
        for (int i = 0; i < 4; i++) send(2'd0, 12'd2048);
        expect_result("mid_scale", 0, 127);
    endtask

    task automatic test_interleave;
        send(2'd0, 12'd100);  send(2'd2, 12'd4000);
        send(2'd0, 12'd200);  send(2'd2, 12'd3000);
        send(2'd0, 12'd300);  send(2'd2, 12'd2000);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL interleave_early: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        send(2'd0, 12'd400);
        expect_result("interleave_ch0", 0, 15);
        send(2'd2, 12'd1000);
        expect_result("interleave_ch2", 2, 155);
    endtask

    task automatic test_hold_stall;
        int lat;
        for (int i = 0; i < 4; i++) send(2'd3, 12'd4095);
        wait_result(lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d cycles expected %0d", lat, LAT);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0]; in_ch = 2'd3; in_data = 12'd0;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd255 || out_ch !== 2'd3 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got v=%b d=%0d c=%0d ready=%b expected 1 255 3 0",
                         i, out_valid, out_data, out_ch, in_ready);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd255) begin
            n_fail++;
            $display("FAIL stall_end: got v=%b d=%0d expected 1 255", out_valid, out_data);
        end
`ifdef ADC_ALARM_EN
        exp_alarm[3] = 1'b1;
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (alarm !== exp_alarm || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_high: got alarm=%b ready=%b expected %b 1", alarm, in_ready, exp_alarm);
        end
        for (int i = 0; i < 4; i++) send(2'd3, 12'd1606);
        expect_result("alarm_low", 3, 100);
    endtask

    task automatic test_bad_channel;
        int lat;
        send5(3'd4, 12'd4095);
        wait_result5(lat);
        n_checks++;
        if (lat !== LAT || e_out_data !== 8'd255 || e_out_ch !== 3'd4) begin
            n_fail++;
            $display("FAIL single_full: got lat=%0d d=%0d c=%0d expected %0d 255 4",
                     lat, e_out_data, e_out_ch, LAT);
        end
        e_out_ready = 1'b1; @(posedge clk); #1; e_out_ready = 1'b0;

        send5(3'd5, 12'd4095);
        n_checks++;
        if (e_err_ch !== 1'b1 || e_busy !== 1'b0 || e_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL badch_pulse: got err=%b busy=%b ready=%b expected 1 0 1",
                     e_err_ch, e_busy, e_in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (e_err_ch !== 1'b0) begin
            n_fail++;
            $display("FAIL badch_width: got err=%b expected 0", e_err_ch);
        end
        send5(3'd7, 12'd4095);
        n_checks++;
        if (e_err_ch !== 1'b1 || e_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL badch7_pulse: got err=%b busy=%b expected 1 0", e_err_ch, e_busy);
        end
        wait_result5(lat);
        n_checks++;
        if (lat !== -1 || err_ch !== 1'b0) begin
            n_fail++;
            $display("FAIL badch_no_result: got lat=%0d main_err=%b expected -1 0", lat, err_ch);
        end

        send5(3'd2, 12'd2048);
        wait_result5(lat);
        n_checks++;
        if (lat !== LAT || e_out_data !== 8'd127 || e_out_ch !== 3'd2) begin
            n_fail++;
            $display("FAIL single_mid: got lat=%0d d=%0d c=%0d expected %0d 127 2",
                     lat, e_out_data, e_out_ch, LAT);
        end
        e_out_ready = 1'b1; @(posedge clk); #1; e_out_ready = 1'b0;

        send5(3'd0, 12'd0);
        wait_result5(lat);
        n_checks++;
        if (lat !== LAT || e_out_data !== 8'd0 || e_out_ch !== 3'd0) begin
            n_fail++;
            $display("FAIL single_zero: got lat=%0d d=%0d c=%0d expected %0d 0 0",
                     lat, e_out_data, e_out_ch, LAT);
        end
        e_out_ready = 1'b1; @(posedge clk); #1; e_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div;
        logic seen;
        send(2'd0, 12'd4095); send(2'd0, 12'd4095);
        for (int i = 0; i < 4; i++) send(2'd1, 12'd4095);
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL middiv_state: got busy=%b valid=%b expected 1 0", busy, out_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_alarm = '0;
        n_checks++;
        if ({out_valid, err_ch, busy} !== 3'b000 || out_data !== 8'd0 || out_ch !== 2'd0
            || alarm !== 4'b0000 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL middiv_reset: got v=%b e=%b b=%b d=%0d c=%0d alarm=%b ready=%b expected 0s and ready 1",
                     out_valid, err_ch, busy, out_data, out_ch, alarm, in_ready);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL middiv_abort: got out_valid during abort window expected none");
        end
        for (int i = 0; i < 4; i++) send(2'd0, 12'd0);
        expect_result("acc_cleared", 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b0;
        e_in_valid = 1'b0; e_in_ch = '0; e_in_data = '0; e_out_ready = 1'b0;
        test_reset();
        test_full_scale();
        test_mid_scale();
        test_interleave();
        test_hold_stall();
        test_bad_channel();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
